// File: rtl/write_dst_fsm_if.sv
// AXI write-channel bundle (AW, W, B) between the write-destination FSM and
// the destination memory port.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge. Valid never depends on ready. Ready may
// depend on valid.
interface write_dst_fsm_if #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 64
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast,
      output bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast,
      input  bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/write_dst_fsm.sv
// Write-destination stage of the DMA engine. It drains beats from the shared
// show-ahead data FIFO and issues one AXI write burst per descriptor. It waits
// for the write response, then pulses wr_fsm_done so the read-source FSM can
// retire the descriptor. Bad descriptors or error responses park the FSM in
// ERROR until clear_error.
module write_dst_fsm #(
   parameter int DATA_W      = 512,
   parameter int ADDR_W      = 64,
   parameter int LEN_W       = 16,
   parameter int MAX_BURST   = 256,
   parameter int PERF_CNTR_W = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   // descriptor
   input  logic                   desc_go,
   input  logic                   desc_fifo_not_empty,
   input  logic [ADDR_W-1:0]      desc_dst_addr,
   input  logic [LEN_W-1:0]       desc_length,
   input  logic [1:0]             desc_mode,
   input  logic                   clear_error,
   // show-ahead data FIFO
   input  logic                   fifo_empty,
   input  logic [DATA_W-1:0]      fifo_rd_data,
   output logic                   fifo_rd_en,
   // AXI write channels
   write_dst_fsm_if.master        axi,
   // status and performance
   output logic                   wr_fsm_done,
   output logic                   busy,
   output logic                   stopped_on_error,
   output logic [5:0]             wr_state,
   output logic [PERF_CNTR_W-1:0] wr_clk_cnt,
   output logic [PERF_CNTR_W-1:0] wr_valid_cnt
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

   localparam logic [1:0] MODE_STAND_BY   = 2'd0;
   localparam logic [1:0] MODE_HOST_TO_DDR = 2'd1;

   localparam logic [1:0] BURST_INCR = 2'd1;
   localparam logic [1:0] BURST_WRAP = 2'd2;

   typedef enum logic [5:0] {
      S_IDLE       = 6'b000001,
      S_ADDR_SETUP = 6'b000010,
      S_DATA       = 6'b000100,
      S_WAIT_RSP   = 6'b001000,
      S_DONE       = 6'b010000,
      S_ERROR      = 6'b100000
   } state_t;

   state_t state;
   state_t state_nxt;

   // Descriptor captured at acceptance so the bus stays stable while the
   // upstream descriptor FIFO moves on.
   logic [ADDR_W-1:0] dst_addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [1:0]        mode_q;
   logic [LEN_W-1:0]  beat_cnt;

   logic desc_req;
   logic desc_bad;
   logic desc_accept;
   logic w_valid_int;
   logic w_hs;
   logic last_beat;
   logic in_transfer;

   // A descriptor is rejected outright (no bus activity) when its length is
   // out of range or it asks for the stand-by mode.
   assign desc_req    = desc_go && desc_fifo_not_empty;
   assign desc_bad    = (desc_length == '0) ||
                        (desc_length > LEN_W'(MAX_BURST)) ||
                        (desc_mode == MODE_STAND_BY);
   assign desc_accept = (state == S_IDLE) && desc_req && !desc_bad;

   // W channel: valid follows FIFO occupancy directly, so an empty FIFO simply
   // opens a gap in the burst. A pop happens only on an accepted beat.
   assign w_valid_int = (state == S_DATA) && !fifo_empty;
   assign w_hs        = w_valid_int && axi.wready;
   assign last_beat   = (beat_cnt == (len_q - LEN_W'(1)));
   assign in_transfer = (state == S_ADDR_SETUP) || (state == S_DATA) ||
                        (state == S_WAIT_RSP);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (desc_req) begin
               state_nxt = desc_bad ? S_ERROR : S_ADDR_SETUP;
            end
         end
         S_ADDR_SETUP: begin
            if (axi.awready) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_hs && last_beat) begin
               state_nxt = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (axi.bvalid) begin
               // bresp[1] set means SLVERR or DECERR.
               state_nxt = axi.bresp[1] ? S_ERROR : S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         S_ERROR: begin
            if (clear_error) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Descriptor capture, beat counter and performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dst_addr_q   <= '0;
         len_q        <= '0;
         mode_q       <= '0;
         beat_cnt     <= '0;
         wr_clk_cnt   <= '0;
         wr_valid_cnt <= '0;
      end else begin
         if (desc_accept) begin
            dst_addr_q   <= desc_dst_addr;
            len_q        <= desc_length;
            mode_q       <= desc_mode;
            beat_cnt     <= '0;
            wr_clk_cnt   <= '0;
            wr_valid_cnt <= '0;
         end else begin
            if (in_transfer) begin
               wr_clk_cnt <= wr_clk_cnt + PERF_CNTR_W'(1);
            end
            if (w_hs) begin
               beat_cnt     <= beat_cnt + LEN_W'(1);
               wr_valid_cnt <= wr_valid_cnt + PERF_CNTR_W'(1);
            end
         end
      end
   end

   // Outputs decoded from the current state; everything idles at zero.
   always_comb begin
      axi.awvalid      = 1'b0;
      axi.awaddr       = '0;
      axi.awlen        = '0;
      axi.awsize       = '0;
      axi.awburst      = '0;
      axi.wvalid       = 1'b0;
      axi.wdata        = '0;
      axi.wstrb        = '0;
      axi.wlast        = 1'b0;
      axi.bready       = 1'b0;
      fifo_rd_en       = 1'b0;
      wr_fsm_done      = 1'b0;
      busy             = 1'b0;
      stopped_on_error = 1'b0;
      unique case (state)
         S_IDLE: begin
         end
         S_ADDR_SETUP: begin
            busy        = 1'b1;
            axi.awvalid = 1'b1;
            axi.awaddr  = dst_addr_q;
            axi.awlen   = 8'(len_q - LEN_W'(1));
            axi.awsize  = AW_SIZE;
            axi.awburst = (mode_q == MODE_HOST_TO_DDR) ? BURST_WRAP : BURST_INCR;
         end
         S_DATA: begin
            busy       = 1'b1;
            axi.wvalid = w_valid_int;
            axi.wdata  = fifo_rd_data;
            axi.wstrb  = '1;
            axi.wlast  = last_beat;
            fifo_rd_en = w_hs;
         end
         S_WAIT_RSP: begin
            busy       = 1'b1;
            axi.bready = 1'b1;
         end
         S_DONE: begin
            busy        = 1'b1;
            wr_fsm_done = 1'b1;
         end
         S_ERROR: begin
            stopped_on_error = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign wr_state = state;

endmodule
